// File: rtl/chip_pkg.sv
// Shared CHIP tile constants, the edge-row FIFO entry and a popcount helper.
// EDGE_POPCOUNT_EN adds a per-row popcount field to the entry.
package chip_pkg;
  localparam int TILE_OUT_DIM  = 18;
  localparam int TILE_BITS     = 324;
  localparam int TILE_IN_WORDS = 80;

  typedef struct packed {
    logic [4:0]              idx;
    logic                    last;
`ifdef EDGE_POPCOUNT_EN
    logic [4:0]              pop;
`endif
    logic [TILE_OUT_DIM-1:0] data;
  } row_entry_t;

  function automatic logic [4:0] popcount(input logic [TILE_OUT_DIM-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < TILE_OUT_DIM; i++) n = n + 5'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/edge_row_fifo.sv
// Synchronous row FIFO with registered full/empty/count flags.
// Entry width is generic; EDGE_POPCOUNT_EN only changes what the top stores.
module edge_row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count_nx;
  logic             do_push, do_pop;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_nx = count;
    if (do_push && !do_pop)      count_nx = count + 1'b1;
    else if (do_pop && !do_push) count_nx = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nx;
      full  <= (count_nx == (AW+1)'(DEPTH));
      empty <= (count_nx == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/edge_row_packer.sv
// Packs the serial hysteresis edge stream into MSB-first rows and queues them.
// Define EDGE_POPCOUNT_EN to add the row_pop output carried with each row.
module edge_row_packer
  import chip_pkg::*;
#(
  parameter int ROW_W      = TILE_OUT_DIM,
  parameter int ROWS       = TILE_OUT_DIM,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             edge_in,
  input  logic             readable,
  output logic [ROW_W-1:0] row_data,
  output logic [4:0]       row_idx,
  output logic             row_last,
  output logic             row_valid,
  input  logic             row_ready,
`ifdef EDGE_POPCOUNT_EN
  output logic [4:0]       row_pop,
`endif
  output logic             tile_done,
  output logic             overflow
);
  localparam int BW = (ROW_W > 1) ? $clog2(ROW_W) : 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state, state_nx;
  logic [BW-1:0]    bit_cnt;
  logic [4:0]       row_cnt;
  logic [ROW_W-2:0] shreg;
  logic [ROW_W-1:0] row_word;
  logic             bit_end, row_end, push, pop, drop;
  logic             fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;
  logic             tile_done_q, overflow_q;
  row_entry_t       wr_entry, rd_entry;

  assign bit_end  = (bit_cnt == BW'(ROW_W-1));
  assign row_end  = (row_cnt == 5'(ROWS-1));
  assign push     = readable & bit_end;
  assign row_word = {shreg, edge_in};
  assign pop      = row_valid & row_ready;
  // Upstream cannot stall: a row arriving at a full, non-draining FIFO is lost.
  assign drop     = push & fifo_full & ~pop;

  always_comb begin
    wr_entry      = '0;
    wr_entry.idx  = row_cnt;
    wr_entry.last = row_end;
    wr_entry.data = TILE_OUT_DIM'(row_word);
`ifdef EDGE_POPCOUNT_EN
    wr_entry.pop  = popcount(wr_entry.data);
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (readable) state_nx = (push && row_end) ? IDLE : COLLECT;
      COLLECT: if (push && row_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Old bits fall off the top of shreg, so no clear is needed between rows.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= '0;
      row_cnt     <= '0;
      shreg       <= '0;
      tile_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      tile_done_q <= push & row_end;
      if (drop) overflow_q <= 1'b1;
      if (readable) begin
        shreg   <= row_word[ROW_W-2:0];
        bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
        if (bit_end) row_cnt <= row_end ? '0 : row_cnt + 1'b1;
      end
    end
  end

  edge_row_fifo #(
    .WIDTH ($bits(row_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

  assign row_valid = ~fifo_empty & ~reset;
  assign row_data  = row_valid ? rd_entry.data[ROW_W-1:0] : '0;
  assign row_idx   = row_valid ? rd_entry.idx : '0;
  assign row_last  = row_valid & rd_entry.last;
`ifdef EDGE_POPCOUNT_EN
  assign row_pop   = row_valid ? rd_entry.pop : '0;
`endif
  assign tile_done = tile_done_q & ~reset;
  assign overflow  = overflow_q & ~reset;
endmodule

// File: doc/edge_row_packer.md
EDGE_ROW_PACKER -- requirements
Module: edge_row_packer

Interface
REQ-001 SHALL have parameter ROW_W, default 18, the edge bits per output row.
REQ-002 SHALL have parameter ROWS, default 18, the rows per tile.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the row-buffer entries (power of two).
REQ-004 SHALL have port clk, input, 1 bit, the only clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port edge_in, input, 1 bit, the serial hysteresis edge result from CHIP edge_out.
REQ-007 SHALL have port readable, input, 1 bit; edge_in is valid only when it is 1.
REQ-008 SHALL have port row_data, output, ROW_W bits, the packed row.
REQ-009 SHALL have port row_idx, output, 5 bits, the row number 0..ROWS-1.
REQ-010 SHALL have port row_last, output, 1 bit, set on the final row of a tile.
REQ-011 SHALL have port row_valid, output, 1 bit, the FIFO head-valid flag.
REQ-012 SHALL have port row_ready, input, 1 bit, consumer accept.
REQ-013 SHALL have port tile_done, output, 1 bit, a one-cycle pulse when the 324th bit of a tile is captured.
REQ-014 SHALL have port overflow, output, 1 bit, a sticky row-drop flag.

Function
REQ-015 SHALL capture edge_in on each rising clk edge where readable=1, and SHALL ignore it otherwise; gaps of any length are legal.
REQ-016 SHALL place the first captured bit of a row at row_data[ROW_W-1] (column 0, MSB-first) and the last at bit 0.
REQ-017 SHALL keep bit_cnt 0..ROW_W-1 and row_cnt 0..ROWS-1, with both wrapping to 0 after the last value.
REQ-018 SHALL push {row_cnt, row_last, data} into the FIFO in the same cycle the ROW_W-th bit is captured, so the entry is visible at row_valid on the next cycle (latency 1).
REQ-019 SHALL pulse tile_done for exactly one cycle, in the cycle after the push with row_cnt=ROWS-1.
REQ-020 SHALL transfer a row when row_valid=1 and row_ready=1, with the FIFO head advancing that cycle.
REQ-021 SHALL hold row_data, row_idx and row_last stable while row_valid=1 and row_ready=0.
REQ-022 SHALL accept a push when the FIFO is full only if a pop occurs in the same cycle; occupancy then stays FIFO_DEPTH.
REQ-023 SHALL, on a push to a full FIFO with no pop, drop the row, set overflow, and still advance row_cnt; the upstream stage cannot stall.
REQ-024 SHALL keep overflow set until reset.
REQ-025 SHALL, on a push to an empty FIFO, raise row_valid the next cycle with no extra bubble.
REQ-026 SHALL implement the tile state machine as IDLE (bit_cnt=0, row_cnt=0) -> COLLECT (first readable bit) -> IDLE (after the tile's last bit).
REQ-027 SHALL treat any readable=1 in IDLE as the start of a new tile.

Reset
REQ-028 SHALL, while reset=1, clear bit_cnt, row_cnt, the shift register, the FIFO pointers and the FIFO count.
REQ-029 SHALL drive row_valid=0, tile_done=0, overflow=0, row_data=0, row_idx=0 and row_last=0 while reset=1.
REQ-030 SHALL discard any partial row or tile on a reset mid-tile, and SHALL treat the next readable bit as row 0, column 0.
REQ-031 SHALL give reset priority over a simultaneous capture or pop.

Configuration
REQ-032 SHALL, with EDGE_POPCOUNT_EN defined, add output row_pop (5 bits), the number of 1s in row_data, stored with the FIFO entry and held stable with it.
REQ-033 SHALL, without EDGE_POPCOUNT_EN, omit the row_pop port and its FIFO storage; all other behaviour is identical.

Structure
REQ-034 SHALL take the constants TILE_OUT_DIM=18, TILE_BITS=324, TILE_IN_WORDS=80 and the row-entry struct type from the shared package chip_pkg.
REQ-035 SHALL implement the FIFO as one sub-module, edge_row_fifo (sync, registered outputs, full/empty/count), with the packer FSM and counters in the top.

Verification
REQ-036 SHALL test one tile: 324 contiguous readable bits of pattern 18'h2AAAA repeated, row_ready=1 -> 18 rows, each 18'h2AAAA, row_idx 0..17, row_last only on 17, one tile_done pulse.
REQ-037 SHALL test gaps: readable toggled 1/0 each cycle for 36 bits -> two rows, identical to the contiguous result, and no extra pushes.
REQ-038 SHALL test backpressure: row_ready=0 for 5 rows -> FIFO fills at 4, row 4 dropped, overflow=1, and after release rows 0..3 drain intact with row_idx 0..3.
REQ-039 SHALL test full with a simultaneous pop: FIFO full, row_ready=1 in the push cycle -> no drop, overflow stays 0.
REQ-040 SHALL test reset mid-tile: reset after 100 bits, then 324 bits of all ones -> 18 rows of 18'h3FFFF starting at row_idx 0.
REQ-041 SHALL test the macro: with EDGE_POPCOUNT_EN, row 18'h00F0F -> row_pop=8; without it, the build has no row_pop port.
